// File: rtl/instr_fetch_pkg.sv
// Shared definitions for the fetch stage and the pipelined processor:
// instruction field layout, opcodes, bubble encoding and FSM states.
package instr_fetch_pkg;

    localparam logic [1:0] OP_ADD  = 2'b00;
    localparam logic [1:0] OP_SUB  = 2'b01;
    localparam logic [1:0] OP_LOAD = 2'b10;
    localparam logic [1:0] OP_HALT = 2'b11;

    localparam logic [7:0] INSTR_NOP = 8'h00;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_HALT = 2'b10
    } fetch_state_e;

    function automatic logic [1:0] opcode_of(input logic [7:0] word);
        return word[7:6];
    endfunction

    function automatic logic is_halt(input logic [7:0] word);
        return (opcode_of(word) == OP_HALT);
    endfunction

endpackage

// File: rtl/instr_fetch_if.sv
// Bus between the fetch stage and its controller/consumer: program loading,
// run control, and the fetched instruction stream with status.
interface instr_fetch_if #(
    parameter int AW = 4
);
    logic          prog_we;
    logic [AW-1:0] prog_addr;
    logic [7:0]    prog_data;
    logic          start;
    logic          stall;
    logic [7:0]    instr;
    logic [AW-1:0] pc;
    logic          busy;
    logic          halted;

    modport master (
        output prog_we, prog_addr, prog_data, start, stall,
        input  instr, pc, busy, halted
    );

    modport slave (
        input  prog_we, prog_addr, prog_data, start, stall,
        output instr, pc, busy, halted
    );
endinterface

// File: rtl/instr_fetch_prog_mem.sv
// Program memory: DEPTH x 8, one synchronous write port, one asynchronous
// read port. Contents are deliberately not reset.
module prog_mem #(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [7:0]    wdata,
    input  logic [AW-1:0] raddr,
    output logic [7:0]    rdata
);
    logic [7:0] mem_q [DEPTH];

    // Write port.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch stage: IDLE/RUN/HALT controller, program counter and
// registered instruction output feeding the decode stage.
module instr_fetch
    import instr_fetch_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic          clk,
    input  logic          rst,
    instr_fetch_if.slave  bus
);
    fetch_state_e  state_q, state_d;
    logic [AW-1:0] pc_q, pc_d;
    logic [7:0]    instr_q, instr_d;
    logic [7:0]    mem_rdata_s;
    logic          mem_we_s;

    // Loading is only allowed while the fetcher is not consuming the memory.
    assign mem_we_s = bus.prog_we && (state_q != ST_RUN);

    prog_mem #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_prog_mem (
        .clk   (clk),
        .we    (mem_we_s),
        .waddr (bus.prog_addr),
        .wdata (bus.prog_data),
        .raddr (pc_q),
        .rdata (mem_rdata_s)
    );

    // Next-state, next-PC and next-instruction logic.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = INSTR_NOP;
        case (state_q)
            ST_IDLE, ST_HALT: begin
                if (bus.start) begin
                    state_d = ST_RUN;
                    pc_d    = {AW{1'b0}};
                end else begin
                    state_d = state_q;
                end
            end
            ST_RUN: begin
                if (bus.stall) begin
                    instr_d = INSTR_NOP;
                end else if (is_halt(mem_rdata_s)) begin
                    // HALT word is swallowed; pc stays pointing at it.
                    state_d = ST_HALT;
                    instr_d = INSTR_NOP;
                end else begin
                    instr_d = mem_rdata_s;
                    pc_d    = pc_q + AW'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                pc_d    = {AW{1'b0}};
                instr_d = INSTR_NOP;
            end
        endcase
    end

    // State, PC and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            pc_q    <= {AW{1'b0}};
            instr_q <= INSTR_NOP;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
        end
    end

    assign bus.instr  = instr_q;
    assign bus.pc     = pc_q;
    assign bus.busy   = (state_q == ST_RUN);
    assign bus.halted = (state_q == ST_HALT);

endmodule

// File: tb/tb_instr_fetch.sv
// Directed self-checking bench for instr_fetch.
module tb_instr_fetch;
    logic clk;
    logic rst;
    int   checks;
    int   failures;

    instr_fetch_if #(.AW(4)) bus ();

    instr_fetch #(
        .DEPTH (16),
        .AW    (4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic expect_out(input string tag, input logic [7:0] ei, input logic [3:0] ep,
                              input logic eb, input logic eh);
        chk({tag, ".instr"},  bus.instr, ei);
        chk({tag, ".pc"},     {4'h0, bus.pc}, {4'h0, ep});
        chk({tag, ".busy"},   {7'h00, bus.busy}, {7'h00, eb});
        chk({tag, ".halted"}, {7'h00, bus.halted}, {7'h00, eh});
    endtask

    task automatic write_mem(input logic [3:0] a, input logic [7:0] d);
        bus.prog_we   = 1'b1;
        bus.prog_addr = a;
        bus.prog_data = d;
        step();
        bus.prog_we   = 1'b0;
    endtask

    task automatic pulse_start();
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
    endtask

    initial begin
        checks        = 0;
        failures      = 0;
        rst           = 1'b1;
        bus.prog_we   = 1'b0;
        bus.prog_addr = 4'h0;
        bus.prog_data = 8'h00;
        bus.start     = 1'b0;
        bus.stall     = 1'b0;
        step();
        step();
        expect_out("reset", 8'h00, 4'h0, 1'b0, 1'b0);
        rst = 1'b0;

        // Basic program with HALT at address 2.
        write_mem(4'h0, 8'h0A);
        write_mem(4'h1, 8'h51);
        write_mem(4'h2, 8'hC0);
        expect_out("idle", 8'h00, 4'h0, 1'b0, 1'b0);
        pulse_start();
        expect_out("p1.start", 8'h00, 4'h0, 1'b1, 1'b0);
        step();
        expect_out("p1.f0", 8'h0A, 4'h1, 1'b1, 1'b0);
        step();
        expect_out("p1.f1", 8'h51, 4'h2, 1'b1, 1'b0);
        step();
        expect_out("p1.halt", 8'h00, 4'h2, 1'b0, 1'b1);
        bus.stall = 1'b1;
        step();
        expect_out("p1.halt_hold", 8'h00, 4'h2, 1'b0, 1'b1);
        bus.stall = 1'b0;

        // Stall for two cycles after the first fetch.
        write_mem(4'h0, 8'h11);
        write_mem(4'h1, 8'h12);
        write_mem(4'h2, 8'h13);
        write_mem(4'h3, 8'hC0);
        pulse_start();
        expect_out("p2.start", 8'h00, 4'h0, 1'b1, 1'b0);
        step();
        expect_out("p2.f0", 8'h11, 4'h1, 1'b1, 1'b0);
        bus.stall = 1'b1;
        step();
        expect_out("p2.stall0", 8'h00, 4'h1, 1'b1, 1'b0);
        step();
        expect_out("p2.stall1", 8'h00, 4'h1, 1'b1, 1'b0);
        bus.stall = 1'b0;
        step();
        expect_out("p2.f1", 8'h12, 4'h2, 1'b1, 1'b0);
        step();
        expect_out("p2.f2", 8'h13, 4'h3, 1'b1, 1'b0);
        step();
        expect_out("p2.halt", 8'h00, 4'h3, 1'b0, 1'b1);

        // Write during RUN is dropped; same write in HALT lands.
        pulse_start();
        bus.prog_we   = 1'b1;
        bus.prog_addr = 4'h3;
        bus.prog_data = 8'h2A;
        step();
        bus.prog_we   = 1'b0;
        expect_out("p3.f0", 8'h11, 4'h1, 1'b1, 1'b0);
        step();
        step();
        expect_out("p3.f2", 8'h13, 4'h3, 1'b1, 1'b0);
        step();
        expect_out("p3.run_wr_ignored", 8'h00, 4'h3, 1'b0, 1'b1);
        write_mem(4'h3, 8'h2A);
        write_mem(4'h4, 8'hC0);
        pulse_start();
        step();
        step();
        step();
        step();
        expect_out("p3.halt_wr_taken", 8'h2A, 4'h4, 1'b1, 1'b0);
        step();
        expect_out("p3.halt", 8'h00, 4'h4, 1'b0, 1'b1);

        // No HALT anywhere: PC wraps and fetching continues.
        for (int i = 0; i < 16; i++) begin
            write_mem(i[3:0], 8'h01);
        end
        pulse_start();
        expect_out("p4.start", 8'h00, 4'h0, 1'b1, 1'b0);
        for (int i = 0; i < 16; i++) begin
            step();
            expect_out($sformatf("p4.f%0d", i), 8'h01, 4'(i + 1), 1'b1, 1'b0);
        end
        step();
        expect_out("p4.after_wrap", 8'h01, 4'h1, 1'b1, 1'b0);

        // Start is ignored while running.
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        expect_out("p4.start_in_run", 8'h01, 4'h2, 1'b1, 1'b0);
        step();
        step();
        step();
        expect_out("p5.pc5", 8'h01, 4'h5, 1'b1, 1'b0);

        // Reset mid-RUN wins over everything, memory survives.
        rst       = 1'b1;
        bus.start = 1'b1;
        step();
        rst       = 1'b0;
        bus.start = 1'b0;
        expect_out("p5.reset", 8'h00, 4'h0, 1'b0, 1'b0);
        pulse_start();
        step();
        expect_out("p5.refetch", 8'h01, 4'h1, 1'b1, 1'b0);

        // Write and start on the same edge: first fetch sees new word.
        rst = 1'b1;
        step();
        rst = 1'b0;
        bus.prog_we   = 1'b1;
        bus.prog_addr = 4'h0;
        bus.prog_data = 8'h9F;
        bus.start     = 1'b1;
        step();
        bus.prog_we   = 1'b0;
        bus.start     = 1'b0;
        expect_out("p6.start", 8'h00, 4'h0, 1'b1, 1'b0);
        step();
        expect_out("p6.f0", 8'h9F, 4'h1, 1'b1, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 SHALL have parameter DEPTH, default 16, meaning number of 8-bit program memory entries (power of two).
REQ-002 SHALL have parameter AW, default 4, meaning program address width, log2(DEPTH).
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on the rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port prog_we  input  1  program-memory write enable.
REQ-006 SHALL have port prog_addr  input  AW  program-memory write address.
REQ-007 SHALL have port prog_data  input  8  program-memory write data.
REQ-008 SHALL have port start  input  1  begin fetching from address 0.
REQ-009 SHALL have port stall  input  1  hold the PC and emit a bubble this cycle.
REQ-010 SHALL have port instr  output  8  registered instruction to the downstream decode stage.
REQ-011 SHALL have port pc  output  AW  registered program counter.
REQ-012 SHALL have port busy  output  1  high while the FSM is in RUN.
REQ-013 SHALL have port halted  output  1  high while the FSM is in HALT.

Function
REQ-014 SHALL implement a three-state FSM with states IDLE, RUN and HALT.
REQ-015 SHALL define the instruction format as opcode [7:6], op1 [5:3] and op2 [2:0]; opcodes are 00 ADD, 01 SUB, 10 LOAD and 11 HALT.
REQ-016 SHALL use 8'h00 as the bubble (NOP) encoding.
REQ-017 SHALL write prog_data to mem[prog_addr] on an edge with prog_we=1 only in IDLE or HALT; writes in RUN are ignored.
REQ-018 SHALL, in IDLE or HALT with start=1, set pc=0 and enter RUN at that edge; instr=8'h00 at that edge.
REQ-019 SHALL, in RUN with stall=0, fetch at each edge: instr<=mem[pc] and pc<=pc+1 modulo DEPTH; the first valid instruction appears one edge after entering RUN.
REQ-020 SHALL, in RUN with stall=1, drive instr<=8'h00 and hold pc; stall has priority over fetch.
REQ-021 SHALL, in RUN with stall=0 and mem[pc][7:6]==2'b11, drive instr<=8'h00, hold pc at the HALT address and enter HALT; the HALT word is never forwarded.
REQ-022 SHALL wrap pc from DEPTH-1 to 0 and continue fetching when no HALT is met; there is no end-of-program state.
REQ-023 SHALL drive instr=8'h00 in IDLE and HALT.
REQ-024 SHALL ignore stall outside RUN, and ignore start in RUN.
REQ-025 SHALL, on prog_we=1 and start=1 at the same edge, perform the write; the first fetch, one edge later, observes the written value.
REQ-026 SHALL have busy and halted decoded from the registered state, so both are glitch-free.

Reset
REQ-027 SHALL, on rst=1 at an edge, force state=IDLE, pc=0, instr=8'h00, busy=0 and halted=0, overriding every other input including mid-RUN.
REQ-028 SHALL not clear program memory on reset; contents persist across reset.

Structure
REQ-029 SHALL take the opcode constants (ADD, SUB, LOAD, HALT), the NOP constant 8'h00 and the FSM state encodings from a shared package, also used by the pipelined processor.
REQ-030 SHALL place the memory in one sub-module, prog_mem: DEPTH x 8, one synchronous write port and one asynchronous read port; the FSM, PC and output register stay in instr_fetch.

Verification
REQ-031 SHALL cover: load mem[0..2]=8'h0A, 8'h51, 8'hC0, then pulse start -> instr sequence 00, 0A, 51, 00, with halted=1 from the edge that fetches addr 2 and pc=2.
REQ-032 SHALL cover: running program 8'h11, 8'h12, 8'h13 with stall=1 for 2 cycles after the first fetch -> instr 11, 00, 00, 12, 13, with pc held during the stall.
REQ-033 SHALL cover: all 16 words 8'h01, no HALT -> after mem[15]=01 the pc wraps to 0 and fetching continues, busy stays 1.
REQ-034 SHALL cover: rst=1 asserted mid-RUN at pc=5 -> next edge state IDLE, pc=0, instr=00, busy=0; a subsequent start refetches mem[0] unchanged.
REQ-035 SHALL cover: prog_we to addr 3 during RUN -> mem[3] unchanged on its next fetch; the same write in HALT takes effect.
REQ-036 SHALL cover: prog_we addr 0 = 8'h9F with start in the same cycle -> the first fetched instr is 9F.
